sdram_rom_loader: RTL
=====================

SDRAM_ROM_LOADER -- requirements
Module: sdram_rom_loader

Interface
- REQ-001 SHALL have parameter ADDR_W, default 24: width of the ioctl byte address.
- REQ-002 SHALL have parameter NREG, default 4: number of ROM regions; legal range 1..8.
- REQ-003 SHALL have parameter RST_HOLD, default 65535: core-reset hold time, in clk_sys cycles.
- REQ-004 SHALL have parameter ROM_INDEX, default 0: the ioctl_index value that is accepted as ROM data.
- REQ-005 SHALL have port clk_sys, input, 1 bit: the only clock.
- REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have ports ioctl_download (in, 1), ioctl_index (in, 8), ioctl_wr (in, 1), ioctl_addr (in, ADDR_W), ioctl_dout (in, 8): the HPS download stream.
- REQ-008 SHALL have port ioctl_wait, output, 1 bit: stall request to the HPS.
- REQ-009 SHALL have port region_base, input, NREG*ADDR_W bits: region start byte addresses, ascending; slice i belongs to region i.
- REQ-010 SHALL have ports mem_req (out, 1, toggle) and mem_ack (in, 1, toggle): the memory write handshake.
- REQ-011 SHALL have ports mem_addr (out, ADDR_W-1, word address), mem_din (out, 16), mem_be (out, 2, bit0 = low byte), mem_region (out, max(1,$clog2(NREG))).
- REQ-012 SHALL have ports reset_req (in, 1: user/OSD reset), rom_loaded (out, 1), core_reset (out, 1), overrun (out, 1, sticky).

Function
- REQ-013 A byte SHALL be accepted on a rising edge of ioctl_wr while ioctl_download=1 and ioctl_index==ROM_INDEX; all other edges are ignored.
- REQ-014 The FSM SHALL have three states: IDLE, HOLD (one even byte pending), ISSUE (request outstanding).
- REQ-015 In IDLE, an even-address byte SHALL be latched into the low lane, and the FSM SHALL go to HOLD.
- REQ-016 In IDLE, an odd-address byte SHALL be issued at once with mem_be=10, and the FSM SHALL go to ISSUE.
- REQ-017 In HOLD, an odd byte whose address is the held address+1 SHALL issue one word with mem_be=11.
- REQ-018 In HOLD, any other byte SHALL first flush the held byte with mem_be=01; the new byte is then processed as in IDLE once the flush is acked.
- REQ-019 In HOLD, a falling edge of ioctl_download SHALL flush the held byte with mem_be=01.
- REQ-020 On issue, mem_addr, mem_din, mem_be and mem_region SHALL be registered first, and mem_req SHALL toggle on the same clock edge; all four SHALL stay stable until acked.
- REQ-021 In ISSUE, the request SHALL complete when mem_ack==mem_req; the FSM SHALL then return to IDLE, or to HOLD if a byte was deferred.
- REQ-022 ioctl_wait SHALL be 1 in ISSUE and while a byte is deferred, and 0 otherwise.
- REQ-023 A byte accepted while in ISSUE that cannot be deferred (one deferred already) SHALL be dropped and SHALL set overrun to 1 until reset.
- REQ-024 mem_region SHALL be the highest i with byte address >= region_base[i]; an address below region_base[0] SHALL give region 0.
- REQ-025 rom_loaded SHALL set one cycle after the first falling edge of ioctl_download (with index match) once the FSM is IDLE with no flush pending; it SHALL stay set until reset_n.
- REQ-026 A 16-bit counter SHALL reload to RST_HOLD while reset_req=1, ioctl_download=1, or rom_loaded=0, and decrement to 0 otherwise.
- REQ-027 core_reset SHALL be registered (counter != 0).
- REQ-028 Address wrap: ioctl_addr at all-ones SHALL produce a single-byte flush; there is no carry into a new word.

Reset
- REQ-029 On reset_n=0, the FSM SHALL go to IDLE, and mem_req, ioctl_wait, rom_loaded and overrun SHALL be 0.
- REQ-030 On reset_n=0, core_reset SHALL be 1, the counter SHALL be RST_HOLD, and mem_addr, mem_din and mem_be SHALL be 0.
- REQ-031 The loader SHALL sample mem_ack into its reference on reset release, so any outstanding memory request is abandoned.

Configuration
- REQ-032 With SDRAM_ROM_LOADER_CHECKSUM_EN defined, a 16-bit output checksum SHALL be the modulo-2^16 sum of all accepted bytes, cleared on the rising edge of ioctl_download.
- REQ-033 Without SDRAM_ROM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL not exist.

Verification
- REQ-034 Bytes 0x11@0, 0x22@1, with ack 2 cycles later -> one request: mem_addr=0, mem_din=0x2211, be=11, ioctl_wait high for 3 cycles.
- REQ-035 Bytes 0xAA@4 then 0xBB@9 -> two requests: addr 2 with be=01 and din[7:0]=0xAA, then addr 4 with be=10 and din[15:8]=0xBB.
- REQ-036 region_base={0x0000,0x8000,0x10000,0x12000}, byte@0x10001 -> mem_region=2; byte@0x7FFF -> mem_region=0.
- REQ-037 Download ends with an even byte held -> flush with be=01; rom_loaded rises after its ack; core_reset falls RST_HOLD+1 cycles later; reset_req pulse re-arms the full hold.
- REQ-038 Two bytes strobed while a request is unacked -> first is deferred and issued after the ack, second is dropped with overrun=1; reset_n low mid-ISSUE -> all outputs at reset values.
- REQ-039 With SDRAM_ROM_LOADER_CHECKSUM_EN, bytes 0xFF, 0x02 -> checksum=0x0101.

Source files
------------

// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: packs the HPS ioctl byte stream into 16-bit toggle-handshake
// memory writes, tags each write with its ROM region, and holds the core in reset
// until the ROM has landed.
// Optional feature: define SDRAM_ROM_LOADER_CHECKSUM_EN to add a 16-bit
// byte-sum output "checksum".
module sdram_rom_loader #(
  parameter int ADDR_W    = 24,
  parameter int NREG      = 4,
  parameter int RST_HOLD  = 65535,
  parameter int ROM_INDEX = 0,
  localparam int REG_W    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  input  logic [NREG*ADDR_W-1:0] region_base,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [ADDR_W-2:0]      mem_addr,
  output logic [15:0]            mem_din,
  output logic [1:0]             mem_be,
  output logic [REG_W-1:0]       mem_region,
  input  logic                   reset_req,
  output logic                   rom_loaded,
  output logic                   core_reset,
  output logic                   overrun
`ifdef SDRAM_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic                wr_prev_q, dl_prev_q, started_q;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d, def_addr_q, def_addr_d;
  logic [7:0]          hold_data_q, hold_data_d, def_data_q, def_data_d;
  logic                def_valid_q, def_valid_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-2:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_din_q, mem_din_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic [REG_W-1:0]    mem_region_q, mem_region_d;
  logic                end_pend_q, end_pend_d;
  logic                rom_loaded_q, rom_loaded_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                core_reset_q, core_reset_d;

  logic                index_ok, byte_acc, dl_fall, ack_done, idle_clear;
  logic                issue, start;
  logic [ADDR_W-1:0]   iss_addr, st_addr;
  logic [15:0]         iss_din;
  logic [1:0]          iss_be;
  logic [7:0]          st_data;

  // Highest region whose base is at or below the address; region 0 otherwise.
  function automatic logic [REG_W-1:0] region_of(input logic [ADDR_W-1:0] a);
    logic [REG_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++)
      if (a >= region_base[i*ADDR_W +: ADDR_W]) r = REG_W'(i);
    return r;
  endfunction

  // Byte strobes are ignored until the ack reference has been captured.
  assign index_ok   = (ioctl_index == 8'(ROM_INDEX));
  assign byte_acc   = started_q & ioctl_wr & ~wr_prev_q & ioctl_download & index_ok;
  assign dl_fall    = dl_prev_q & ~ioctl_download & index_ok;
  assign ack_done   = (mem_ack == mem_req_q);
  assign idle_clear = (state_q == S_IDLE) && !def_valid_q;

  // Next-state, packing and request issue.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    def_valid_d  = def_valid_q;
    def_addr_d   = def_addr_q;
    def_data_d   = def_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_be_d     = mem_be_q;
    mem_region_d = mem_region_q;
    overrun_d    = overrun_q;
    issue        = 1'b0;
    iss_addr     = hold_addr_q;
    iss_din      = {8'h00, hold_data_q};
    iss_be       = 2'b01;
    start        = 1'b0;
    st_addr      = ioctl_addr;
    st_data      = ioctl_dout;

    case (state_q)
      S_IDLE: if (byte_acc) start = 1'b1;
      S_HOLD: begin
        if (byte_acc) begin
          issue = 1'b1;
          if (ioctl_addr[0] && ioctl_addr[ADDR_W-1:1] == hold_addr_q[ADDR_W-1:1]) begin
            iss_din = {ioctl_dout, hold_data_q};
            iss_be  = 2'b11;
          end else begin
            // Flush the lone low byte now; the new byte waits for the ack.
            def_valid_d = 1'b1;
            def_addr_d  = ioctl_addr;
            def_data_d  = ioctl_dout;
          end
        end else if (dl_fall || end_pend_q) begin
          issue = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ack_done) begin
          state_d = S_IDLE;
          if (def_valid_q) begin
            def_valid_d = 1'b0;
            start       = 1'b1;
            st_addr     = def_addr_q;
            st_data     = def_data_q;
            if (byte_acc) overrun_d = 1'b1;
          end else if (byte_acc) begin
            start = 1'b1;
          end
        end else if (byte_acc) begin
          if (def_valid_q) begin
            overrun_d = 1'b1;
          end else begin
            def_valid_d = 1'b1;
            def_addr_d  = ioctl_addr;
            def_data_d  = ioctl_dout;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh byte: odd goes straight out on the high lane, even waits for its partner.
    if (start) begin
      if (st_addr[0]) begin
        issue    = 1'b1;
        iss_addr = st_addr;
        iss_din  = {st_data, 8'h00};
        iss_be   = 2'b10;
      end else begin
        state_d     = S_HOLD;
        hold_addr_d = st_addr;
        hold_data_d = st_data;
      end
    end

    if (issue) begin
      state_d      = S_ISSUE;
      mem_addr_d   = iss_addr[ADDR_W-1:1];
      mem_din_d    = iss_din;
      mem_be_d     = iss_be;
      mem_region_d = region_of(iss_addr);
      mem_req_d    = ~mem_req_q;
    end

    // First cycle out of reset: align to the memory's ack so nothing looks outstanding.
    if (!started_q) mem_req_d = mem_ack;
  end

  // Load completion and core-reset hold counter.
  always_comb begin
    rom_loaded_d = rom_loaded_q | (end_pend_q & idle_clear);
    end_pend_d   = end_pend_q;
    if (dl_fall)         end_pend_d = 1'b1;
    else if (idle_clear) end_pend_d = 1'b0;
    if (reset_req || ioctl_download || !rom_loaded_q) cnt_d = 16'(RST_HOLD);
    else if (cnt_q != 16'd0)                          cnt_d = cnt_q - 16'd1;
    else                                              cnt_d = cnt_q;
    core_reset_d = (cnt_q != 16'd0);
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset_n) begin
      // NOTE: there is no RAM here, so every register, datapath included, is reset.
      state_q      <= S_IDLE;
      wr_prev_q    <= 1'b0;
      dl_prev_q    <= 1'b0;
      started_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      def_valid_q  <= 1'b0;
      def_addr_q   <= '0;
      def_data_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_be_q     <= '0;
      mem_region_q <= '0;
      end_pend_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= 16'(RST_HOLD);
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_prev_q    <= ioctl_wr;
      dl_prev_q    <= ioctl_download;
      started_q    <= 1'b1;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      def_valid_q  <= def_valid_d;
      def_addr_q   <= def_addr_d;
      def_data_q   <= def_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_be_q     <= mem_be_d;
      mem_region_q <= mem_region_d;
      end_pend_q   <= end_pend_d;
      rom_loaded_q <= rom_loaded_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign ioctl_wait = (state_q == S_ISSUE) | def_valid_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_be     = mem_be_q;
  assign mem_region = mem_region_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overrun    = overrun_q;

`ifdef SDRAM_ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running byte sum, restarted when a download begins.
  always_comb begin
    checksum_d = checksum_q;
    if (ioctl_download && !dl_prev_q) checksum_d = 16'd0;
    if (byte_acc) checksum_d = checksum_d + 16'(ioctl_dout);
  end

  // Checksum register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) checksum_q <= 16'd0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
